// File: rtl/jump_input_ctrl_if.sv
// Jump key input / jump state bundle between game logic and jump_input_ctrl.
// master drives the raw key and tick strobe; slave returns conditioned state.
interface jump_input_ctrl_if;
  logic       key_n;
  logic       game_tick;
  logic       pressed;
  logic       press_pulse;
  logic       airborne;
  logic       land_pulse;
  logic [1:0] jump_state;

  modport master (
    output key_n,
    output game_tick,
    input  pressed,
    input  press_pulse,
    input  airborne,
    input  land_pulse,
    input  jump_state
  );

  modport slave (
    input  key_n,
    input  game_tick,
    output pressed,
    output press_pulse,
    output airborne,
    output land_pulse,
    output jump_state
  );
endinterface

// File: rtl/jump_input_ctrl.sv
// Jump key synchroniser/debouncer plus tick-driven player jump FSM.
// Option JUMP_VARIABLE_HEIGHT_EN: releasing the key after one AIR tick lands early.
module jump_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20,
  parameter int AIR_TICKS       = 3,
  parameter int COOLDOWN_TICKS  = 1
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  jump_input_ctrl_if.slave bus
);

  localparam int TICK_MAX =
    (AIR_TICKS > COOLDOWN_TICKS) ? AIR_TICKS : COOLDOWN_TICKS;
  localparam int TCNT_W = $clog2(TICK_MAX + 1);

  localparam logic [CNT_W-1:0]  DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DB_ONE   = CNT_W'(1);
  localparam logic [TCNT_W-1:0] AIR_LOAD = TCNT_W'(AIR_TICKS);
  localparam logic [TCNT_W-1:0] CD_LOAD  = TCNT_W'(COOLDOWN_TICKS);
  localparam logic [TCNT_W-1:0] T_ONE    = TCNT_W'(1);
  localparam logic [TCNT_W-1:0] T_ZERO   = '0;
  localparam bit                HAS_CD   = (COOLDOWN_TICKS > 0);

  typedef enum logic [1:0] {
    ST_GROUND = 2'b00,
    ST_AIR    = 2'b01,
    ST_COOL   = 2'b10
  } state_t;

  logic r_sync1;
  logic r_sync2;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.key_n;
      r_sync2 <= r_sync1;
    end
  end

  logic             r_stable;
  logic             r_stable_d;
  logic [CNT_W-1:0] r_db_cnt;
  logic             w_diff;
  logic             w_db_done;
  logic             w_pressed;
  logic             w_press_pulse;

  assign w_diff    = r_sync2 ^ r_stable;
  assign w_db_done = w_diff && (r_db_cnt == DB_LAST);

  // Any return to the stable level restarts the count, so bounces never accumulate.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_stable   <= 1'b1;
      r_stable_d <= 1'b1;
      r_db_cnt   <= '0;
    end else begin
      r_stable_d <= r_stable;
      if (w_db_done) begin
        r_stable <= r_sync2;
        r_db_cnt <= '0;
      end else if (w_diff) begin
        r_db_cnt <= r_db_cnt + DB_ONE;
      end else begin
        r_db_cnt <= '0;
      end
    end
  end

  assign w_pressed     = ~r_stable;
  assign w_press_pulse = r_stable_d & ~r_stable;

  state_t              r_state;
  logic [TCNT_W-1:0]   r_tcnt;
  logic                r_pending;
  state_t              w_state_nx;
  logic [TCNT_W-1:0]   w_tcnt_nx;
  logic                w_pending_nx;
  logic                w_st_ground;
  logic                w_st_air;
  logic                w_st_cool;
  logic                w_req;
  logic                w_air_end;

  assign w_st_ground = (r_state == ST_GROUND);
  assign w_st_air    = (r_state == ST_AIR);
  assign w_st_cool   = (r_state == ST_COOL);
  assign w_req       = r_pending | w_press_pulse;

`ifdef JUMP_VARIABLE_HEIGHT_EN
  logic w_air_elapsed;
  assign w_air_elapsed = (r_tcnt != AIR_LOAD);
  assign w_air_end     = (r_tcnt == T_ONE) ||
                         (~w_pressed && w_air_elapsed);
`else
  assign w_air_end     = (r_tcnt == T_ONE);
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state   <= ST_GROUND;
      r_tcnt    <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_tcnt    <= w_tcnt_nx;
      r_pending <= w_pending_nx;
    end
  end

  // Presses outside GROUND are dropped rather than queued.
  always_comb begin
    w_state_nx   = r_state;
    w_tcnt_nx    = r_tcnt;
    w_pending_nx = r_pending;
    unique case (1'b1)
      w_st_ground: begin
        if (bus.game_tick && w_req) begin
          w_state_nx   = ST_AIR;
          w_tcnt_nx    = AIR_LOAD;
          w_pending_nx = 1'b0;
        end else if (w_press_pulse) begin
          w_pending_nx = 1'b1;
        end
      end
      w_st_air: begin
        if (bus.game_tick) begin
          if (w_air_end) begin
            w_state_nx = HAS_CD ? ST_COOL : ST_GROUND;
            w_tcnt_nx  = CD_LOAD;
          end else begin
            w_tcnt_nx  = r_tcnt - T_ONE;
          end
        end
      end
      w_st_cool: begin
        if (bus.game_tick) begin
          if (r_tcnt == T_ONE) begin
            w_state_nx = ST_GROUND;
            w_tcnt_nx  = T_ZERO;
          end else begin
            w_tcnt_nx  = r_tcnt - T_ONE;
          end
        end
      end
      default: begin
        w_state_nx   = ST_GROUND;
        w_tcnt_nx    = T_ZERO;
        w_pending_nx = 1'b0;
      end
    endcase
  end

  logic       w_airborne;
  logic       w_land;
  logic [1:0] w_jstate;

  always_comb begin
    w_airborne = 1'b0;
    w_land     = 1'b0;
    w_jstate   = 2'b00;
    w_airborne = w_st_air;
    w_land     = w_st_air && bus.game_tick && w_air_end;
    w_jstate   = r_state;
  end

  assign bus.pressed     = w_pressed;
  assign bus.press_pulse = w_press_pulse;
  assign bus.airborne    = w_airborne;
  assign bus.land_pulse  = w_land;
  assign bus.jump_state  = w_jstate;

endmodule
